flit_operand_injector: RTL and testbench
========================================

FLIT_OPERAND_INJECTOR -- requirements
Module: flit_operand_injector

Interface
REQ-001 SHALL have parameter N, default 26, meaning operand width; the internal flit is 2*N bits.
REQ-002 SHALL have parameter PAYLOAD, default 20, meaning data flits per packet (1..65535).
REQ-003 SHALL have parameter GAP, default 7, meaning idle cycles between packets (0..255).
REQ-004 SHALL have parameter NUM_PKT, default 10, meaning packets per run (1..65535).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port start, input, 1, a one-cycle request to begin a run; sampled only in IDLE.
REQ-008 SHALL have port out_ready, input, 1, the downstream adder-stage accept.
REQ-009 SHALL have port out_valid, output, 1, meaning op_a/op_b hold a new flit.
REQ-010 SHALL have port op_a, output, N, the flit bits [N-1:0], which drive adder input1.
REQ-011 SHALL have port op_b, output, N, the flit bits [2N-1:N], which drive adder input2.
REQ-012 SHALL have ports sop and eop, output, 1 each, marking the first and last flit of a packet; both are qualified by out_valid.
REQ-013 SHALL have port pkt_cnt, output, 16, the number of packets completed in the current run.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1, a one-cycle pulse when the run completes.

Function
REQ-016 SHALL implement the FSM states IDLE, SEND, GAP and DONE.
REQ-017 SHALL go IDLE->SEND on start=1; pkt_cnt, the flit counter and the pattern state clear on this transition.
REQ-018 SHALL, in SEND, assert out_valid and present the current flit; a flit is consumed only when out_valid=1 and out_ready=1 are high in the same cycle.
REQ-019 SHALL, while out_ready=0 in SEND, hold out_valid, op_a, op_b, sop and eop stable.
REQ-020 SHALL step the pattern state P0 -> P1 -> P2 -> P3 -> P0 on each consumed flit.
  - P0 = all zeros
  - P1 = upper N bits ones, lower N bits zeros
  - P2 = all ones
  - P3 = lower N bits ones, upper N bits zeros
REQ-021 SHALL start every packet with pattern state P0 and make the first presented flit its successor P1, giving the flit sequence P1, P2, P3, P0, P1, ...
REQ-022 SHALL assert sop on flit index 0 and eop on flit index PAYLOAD-1; when PAYLOAD=1, both assert on the same flit.
REQ-023 SHALL, when the eop flit is consumed, increment pkt_cnt; the next state is then:
  - DONE if pkt_cnt reaches NUM_PKT
  - otherwise GAP if GAP>0
  - otherwise SEND directly, with no bubble cycle
REQ-024 SHALL, in GAP, hold out_valid=0 for exactly GAP cycles and then return to SEND.
REQ-025 SHALL hold op_a and op_b at the last consumed flit during GAP, DONE and IDLE, so the downstream adder sees no extra toggles.
REQ-026 SHALL, in DONE, assert done for one cycle and return to IDLE on the next cycle; pkt_cnt holds its value until the next start.
REQ-027 SHALL ignore start outside IDLE, including in the DONE cycle.
REQ-028 SHALL reach throughput of one flit per cycle when out_ready=1 is held high; output latency from start to the first out_valid is exactly 1 cycle.

Reset
REQ-029 SHALL, on rst_n=0 at a clock edge, enter IDLE regardless of state, including mid-packet or mid-GAP.
REQ-030 SHALL reset out_valid, sop, eop, busy and done to 0.
REQ-031 SHALL reset op_a, op_b, pkt_cnt, the flit counter and the gap counter to 0, and the pattern state to P0.
REQ-032 SHALL not emit a partial-packet eop or a done pulse after reset.

Structure
REQ-033 SHALL take the FSM state encoding, the four pattern constants (functions of N) and the default parameter values from a shared package, flit_pkg.
REQ-034 SHALL place the pattern successor logic in one sub-module, flit_pattern_gen: current pattern in, next pattern out, purely combinational.
REQ-035 SHALL contain no other sub-modules; the implementation fits within 120-400 lines of RTL.

Verification
REQ-036 SHALL cover defaults (N=26, PAYLOAD=20, GAP=7, NUM_PKT=10), out_ready=1, start pulse -> 200 valid flits in 10 bursts of 20, each burst separated by 7 invalid cycles; done fires once; pkt_cnt=10.
REQ-037 SHALL cover the first packet -> (op_a, op_b) sequence (0, 3FFFFFF), (3FFFFFF, 3FFFFFF), (3FFFFFF, 0), (0, 0), repeating; sop on flit 0, eop on flit 19.
REQ-038 SHALL cover out_ready low for 5 cycles on flit 3 -> outputs frozen at (3FFFFFF, 0) for those cycles; the flit count is unchanged.
REQ-039 SHALL cover GAP=0, PAYLOAD=1, NUM_PKT=3 -> 3 consecutive valid cycles each with sop=eop=1 and value (0, 3FFFFFF); done in the 4th cycle.
REQ-040 SHALL cover rst_n low during packet 4, flit 8 -> the next cycle shows IDLE, out_valid=0, pkt_cnt=0, and no done pulse; a following start replays from P1.
REQ-041 SHALL cover start pulsed while busy -> no effect, and total flits equal PAYLOAD*NUM_PKT.

Source files
------------

// File: rtl/flit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flit_pkg
// Description : Shared definitions for the flit operand injector: default
//               parameter values, FSM state encoding, pattern-state encoding
//               and a constant function that builds the four test patterns
//               for any operand width N.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package flit_pkg;

  // Default parameter values of the injector.
  localparam int c_def_n       = 26;
  localparam int c_def_payload = 20;
  localparam int c_def_gap     = 7;
  localparam int c_def_num_pkt = 10;

  // Widest operand the pattern builder supports; pattern vectors are built
  // at this width and sliced down to 2*N by the user.
  localparam int c_max_n = 256;

  // Injector control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Pattern states of the flit generator.
  typedef enum logic [1:0] {
    PAT_P0 = 2'd0,  // all zeros
    PAT_P1 = 2'd1,  // upper N bits ones, lower N bits zeros
    PAT_P2 = 2'd2,  // all ones
    PAT_P3 = 2'd3   // lower N bits ones, upper N bits zeros
  } pat_e;

  // Builds the 2*n-bit flit for pattern p, zero-extended to 2*c_max_n bits.
  function automatic logic [2*c_max_n-1:0] pat_flit(input int n, input pat_e p);
    logic [2*c_max_n-1:0] r;
    r = '0;
    for (int i = 0; i < 2*c_max_n; i++) begin
      if (i < 2*n) begin
        case (p)
          PAT_P0:  r[i] = 1'b0;
          PAT_P1:  r[i] = (i >= n);
          PAT_P2:  r[i] = 1'b1;
          PAT_P3:  r[i] = (i < n);
          default: r[i] = 1'b0;
        endcase
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flit_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : flit_pattern_gen
// Description : Pattern successor function P0 -> P1 -> P2 -> P3 -> P0.
//               Purely combinational.
// Ports       : i_pat      - current pattern state (pat_e encoding)
//               o_pat_next - successor pattern state (pat_e encoding)
// Revision    : 1.0 - initial release
// ============================================================================
module flit_pattern_gen
  import flit_pkg::*;
(
  input  logic [1:0] i_pat,
  output logic [1:0] o_pat_next
);

  always_comb begin
    o_pat_next = PAT_P0;
    case (pat_e'(i_pat))
      PAT_P0:  o_pat_next = PAT_P1;
      PAT_P1:  o_pat_next = PAT_P2;
      PAT_P2:  o_pat_next = PAT_P3;
      PAT_P3:  o_pat_next = PAT_P0;
      default: o_pat_next = PAT_P0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/flit_operand_injector.sv
`default_nettype none
// ============================================================================
// Module      : flit_operand_injector
// Description : Generates runs of NUM_PKT packets of PAYLOAD flits each,
//               separated by GAP idle cycles, cycling through four operand
//               patterns to exercise a downstream adder. Valid/ready
//               handshake on the output side.
// Ports       : clk       - clock, rising edge
//               rst_n     - synchronous active-low reset
//               start     - one-cycle run request, honoured only in IDLE
//               out_ready - downstream accept
//               out_valid - op_a/op_b carry a flit
//               op_a      - flit bits [N-1:0]
//               op_b      - flit bits [2N-1:N]
//               sop/eop   - first/last flit of a packet (qualified by valid)
//               pkt_cnt   - packets completed in the current run
//               busy      - not IDLE
//               done      - one-cycle pulse at run completion
// Revision    : 1.0 - initial release
// ============================================================================
module flit_operand_injector
  import flit_pkg::*;
#(
  parameter int N       = c_def_n,
  parameter int PAYLOAD = c_def_payload,
  parameter int GAP     = c_def_gap,
  parameter int NUM_PKT = c_def_num_pkt
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [N-1:0]  op_a,
  output logic [N-1:0]  op_b,
  output logic          sop,
  output logic          eop,
  output logic [15:0]   pkt_cnt,
  output logic          busy,
  output logic          done
);

  localparam int c_fw = 2 * N;

  // Pattern constants sliced to the flit width.
  localparam logic [2*c_max_n-1:0] c_full_p0 = pat_flit(N, PAT_P0);
  localparam logic [2*c_max_n-1:0] c_full_p1 = pat_flit(N, PAT_P1);
  localparam logic [2*c_max_n-1:0] c_full_p2 = pat_flit(N, PAT_P2);
  localparam logic [2*c_max_n-1:0] c_full_p3 = pat_flit(N, PAT_P3);
  localparam logic [c_fw-1:0]      c_flit_p0 = c_full_p0[c_fw-1:0];
  localparam logic [c_fw-1:0]      c_flit_p1 = c_full_p1[c_fw-1:0];
  localparam logic [c_fw-1:0]      c_flit_p2 = c_full_p2[c_fw-1:0];
  localparam logic [c_fw-1:0]      c_flit_p3 = c_full_p3[c_fw-1:0];

  localparam logic [15:0] c_last_idx = 16'(PAYLOAD - 1);
  localparam logic [15:0] c_num_pkt  = 16'(NUM_PKT);
  // The gap counter counts down to zero, so it loads GAP-1.
  localparam logic [7:0]  c_gap_load = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_e            state_q, state_d;
  pat_e              pat_q, pat_d;
  logic [15:0]       flit_idx_q, flit_idx_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic [c_fw-1:0]   flit_q, flit_d;

  logic [1:0]        w_pres_pat_raw;
  logic [1:0]        w_load_pat_raw;
  pat_e              w_pres_pat;
  pat_e              w_load_pat;
  logic              w_consume;
  logic              w_last_flit;
  logic              w_last_pkt;
  logic              w_present_new;

  function automatic logic [c_fw-1:0] flit_of(input pat_e p);
    logic [c_fw-1:0] f;
    f = c_flit_p0;
    case (p)
      PAT_P0:  f = c_flit_p0;
      PAT_P1:  f = c_flit_p1;
      PAT_P2:  f = c_flit_p2;
      PAT_P3:  f = c_flit_p3;
      default: f = c_flit_p0;
    endcase
    return f;
  endfunction

  // pat_q is the pattern of the last consumed flit (P0 at packet start);
  // the flit on the bus is always its successor.
  flit_pattern_gen u_pat_pres (
    .i_pat      (pat_q),
    .o_pat_next (w_pres_pat_raw)
  );

  // Successor of the next-cycle pattern state: the flit to present next.
  flit_pattern_gen u_pat_load (
    .i_pat      (pat_d),
    .o_pat_next (w_load_pat_raw)
  );

  assign w_pres_pat  = pat_e'(w_pres_pat_raw);
  assign w_load_pat  = pat_e'(w_load_pat_raw);
  assign w_consume   = (state_q == ST_SEND) && out_ready;
  assign w_last_flit = (flit_idx_q == c_last_idx);
  assign w_last_pkt  = ((pkt_cnt_q + 16'd1) == c_num_pkt);

  // Next-state and counter logic.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    flit_idx_d = flit_idx_q;
    pkt_cnt_d  = pkt_cnt_q;
    gap_cnt_d  = gap_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SEND;
          pat_d      = PAT_P0;
          flit_idx_d = 16'd0;
          pkt_cnt_d  = 16'd0;
          gap_cnt_d  = 8'd0;
        end
      end

      ST_SEND: begin
        if (w_consume) begin
          if (w_last_flit) begin
            pkt_cnt_d  = pkt_cnt_q + 16'd1;
            flit_idx_d = 16'd0;
            pat_d      = PAT_P0;
            if (w_last_pkt) begin
              state_d = ST_DONE;
            end else if (GAP > 0) begin
              state_d   = ST_GAP;
              gap_cnt_d = c_gap_load;
            end else begin
              state_d = ST_SEND;
            end
          end else begin
            flit_idx_d = flit_idx_q + 16'd1;
            pat_d      = w_pres_pat;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The operand register only changes when a new flit will be on the bus
  // next cycle; otherwise it keeps the last consumed (or stalled) flit so
  // the adder inputs do not toggle.
  always_comb begin
    flit_d        = flit_q;
    w_present_new = (state_d == ST_SEND) && ((state_q != ST_SEND) || w_consume);
    if (w_present_new) begin
      flit_d = flit_of(w_load_pat);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pat_q      <= PAT_P0;
      flit_idx_q <= 16'd0;
      pkt_cnt_q  <= 16'd0;
      gap_cnt_q  <= 8'd0;
      flit_q     <= '0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      flit_idx_q <= flit_idx_d;
      pkt_cnt_q  <= pkt_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      flit_q     <= flit_d;
    end
  end

  assign out_valid = (state_q == ST_SEND);
  assign sop       = out_valid && (flit_idx_q == 16'd0);
  assign eop       = out_valid && w_last_flit;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign pkt_cnt   = pkt_cnt_q;
  assign op_a      = flit_q[N-1:0];
  assign op_b      = flit_q[c_fw-1:N];

endmodule
`default_nettype wire

// File: tb/tb_flit_operand_injector.sv
`default_nettype none
// ============================================================================
// Module      : tb_flit_operand_injector
// Description : Self-checking bench for flit_operand_injector. Instance A
//               uses the default configuration, instance B uses GAP=0,
//               PAYLOAD=1, NUM_PKT=3. Outputs of A are compared every cycle
//               against a behavioural model of the packet/gap timeline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flit_operand_injector;

  localparam int N  = 26;
  localparam int P  = 20;
  localparam int G  = 7;
  localparam int NP = 10;
  localparam logic [N-1:0] ONES = {N{1'b1}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A (defaults)
  logic          rst_n_a, start_a, ready_a;
  logic          out_valid_a, sop_a, eop_a, busy_a, done_a;
  logic [N-1:0]  op_a_a, op_b_a;
  logic [15:0]   pkt_cnt_a;

  // Instance B (GAP=0, PAYLOAD=1, NUM_PKT=3)
  logic          rst_n_b, start_b, ready_b;
  logic          out_valid_b, sop_b, eop_b, busy_b, done_b;
  logic [N-1:0]  op_a_b, op_b_b;
  logic [15:0]   pkt_cnt_b;

  flit_operand_injector #(.N(N), .PAYLOAD(P), .GAP(G), .NUM_PKT(NP)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .out_ready(ready_a),
    .out_valid(out_valid_a), .op_a(op_a_a), .op_b(op_b_a), .sop(sop_a),
    .eop(eop_a), .pkt_cnt(pkt_cnt_a), .busy(busy_a), .done(done_a)
  );

  flit_operand_injector #(.N(N), .PAYLOAD(1), .GAP(0), .NUM_PKT(3)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .out_ready(ready_b),
    .out_valid(out_valid_b), .op_a(op_a_b), .op_b(op_b_b), .sop(sop_b),
    .eop(eop_b), .pkt_cnt(pkt_cnt_b), .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Flit value {op_b, op_a} for pattern index k (0..3).
  function automatic logic [2*N-1:0] pat_val(input int k);
    case (k)
      1:       return {ONES, {N{1'b0}}};
      2:       return {ONES, ONES};
      3:       return {{N{1'b0}}, ONES};
      default: return '0;
    endcase
  endfunction

  // Reference model: mode 0 idle, 1 sending, 2 gap, 3 done pulse.
  int              m_mode = 0;
  int              m_pkt  = 0;
  int              m_idx  = 0;
  int              m_gap  = 0;
  logic [2*N-1:0]  m_last = '0;

  int act_flits = 0;
  int act_done  = 0;

  task automatic check_a();
    logic [2*N-1:0] exp_op;
    exp_op = (m_mode == 1) ? pat_val((m_idx + 1) % 4) : m_last;
    chk("a_valid",   out_valid_a, (m_mode == 1));
    chk("a_busy",    busy_a,      (m_mode != 0));
    chk("a_done",    done_a,      (m_mode == 3));
    chk("a_pkt_cnt", pkt_cnt_a,   m_pkt);
    chk("a_ops",     {op_b_a, op_a_a}, exp_op);
    chk("a_sop",     sop_a,       (m_mode == 1) && (m_idx == 0));
    chk("a_eop",     eop_a,       (m_mode == 1) && (m_idx == P - 1));
    if (done_a) act_done++;
  endtask

  // Drive one clock edge of instance A, advance the model, check at negedge.
  task automatic cycle_a(input bit rdy, input bit st, input bit rstn);
    ready_a = rdy;
    start_a = st;
    rst_n_a = rstn;
    if (out_valid_a && rdy && rstn) act_flits++;
    @(posedge clk);
    if (!rstn) begin
      m_mode = 0; m_pkt = 0; m_idx = 0; m_gap = 0; m_last = '0;
    end else begin
      case (m_mode)
        0: if (st) begin m_mode = 1; m_pkt = 0; m_idx = 0; end
        1: if (rdy) begin
             m_last = pat_val((m_idx + 1) % 4);
             if (m_idx == P - 1) begin
               m_idx = 0;
               m_pkt++;
               if (m_pkt == NP) m_mode = 3;
               else if (G > 0) begin m_mode = 2; m_gap = G; end
             end else begin
               m_idx++;
             end
           end
        2: begin m_gap--; if (m_gap == 0) m_mode = 1; end
        default: m_mode = 0;
      endcase
    end
    @(negedge clk);
    check_a();
  endtask

  // Run instance A until the model returns to idle. pct = out_ready
  // probability in percent; spam = pulse start randomly while busy and
  // always in the done cycle.
  task automatic run_to_idle(input int pct, input bit spam, input string tag);
    int c;
    bit rdy, st;
    c = 0;
    while (m_mode != 0 && c < 4000) begin
      rdy = ($urandom_range(0, 99) < pct);
      st  = spam && (($urandom_range(0, 4) == 0) || (m_mode == 3));
      cycle_a(rdy, st, 1'b1);
      c++;
    end
    if (m_mode != 0) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n_a = 1'b0; start_a = 1'b0; ready_a = 1'b1;
    rst_n_b = 1'b0; start_b = 1'b0; ready_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state
    check_a();
    chk("b_rst_valid", out_valid_b, 1'b0);
    chk("b_rst_done",  done_b,      1'b0);
    rst_n_b = 1'b1;
    cycle_a(1'b1, 1'b0, 1'b1);

    // Run 1: out_ready held high
    act_flits = 0; act_done = 0;
    cycle_a(1'b1, 1'b1, 1'b1);
    chk("r1_first_op", {op_b_a, op_a_a}, {ONES, {N{1'b0}}});
    chk("r1_first_sop", sop_a, 1'b1);
    run_to_idle(100, 1'b0, "r1");
    chk("r1_flits",   act_flits, P * NP);
    chk("r1_done",    act_done,  1);
    chk("r1_pkt_cnt", pkt_cnt_a, NP);

    // Run 2: 5-cycle stall on the third flit, then random ready with
    // start pulses while busy
    act_flits = 0; act_done = 0;
    cycle_a(1'b1, 1'b1, 1'b1);
    cycle_a(1'b1, 1'b0, 1'b1);
    cycle_a(1'b1, 1'b0, 1'b1);
    for (int s = 0; s < 5; s++) begin
      cycle_a(1'b0, 1'b1, 1'b1);
      chk("r2_stall_op",    {op_b_a, op_a_a}, {{N{1'b0}}, ONES});
      chk("r2_stall_valid", out_valid_a, 1'b1);
      chk("r2_stall_flits", act_flits, 2);
    end
    run_to_idle(70, 1'b1, "r2");
    chk("r2_flits",   act_flits, P * NP);
    chk("r2_done",    act_done,  1);
    chk("r2_pkt_cnt", pkt_cnt_a, NP);

    // Run 3: reset during the 4th packet, 8th flit
    cycle_a(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 2000 && !(m_mode == 1 && m_pkt == 3 && m_idx == 7); c++) begin
      cycle_a(1'b1, 1'b0, 1'b1);
    end
    chk("r3_reached", (m_mode == 1 && m_pkt == 3 && m_idx == 7), 1'b1);
    act_done = 0;
    cycle_a(1'b1, 1'b0, 1'b0);
    chk("r3_rst_valid", out_valid_a, 1'b0);
    chk("r3_rst_busy",  busy_a,      1'b0);
    chk("r3_rst_pkt",   pkt_cnt_a,   16'd0);
    chk("r3_rst_eop",   eop_a,       1'b0);
    repeat (4) cycle_a(1'b1, 1'b0, 1'b1);
    chk("r3_no_done", act_done, 0);
    act_flits = 0; act_done = 0;
    cycle_a(1'b1, 1'b1, 1'b1);
    chk("r3_replay_op",  {op_b_a, op_a_a}, {ONES, {N{1'b0}}});
    chk("r3_replay_sop", sop_a, 1'b1);
    run_to_idle(85, 1'b0, "r3");
    chk("r3_flits", act_flits, P * NP);
    chk("r3_done",  act_done,  1);

    // Instance B: GAP=0, PAYLOAD=1, NUM_PKT=3
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("b_valid", out_valid_b, 1'b1);
      chk("b_sop",   sop_b,       1'b1);
      chk("b_eop",   eop_b,       1'b1);
      chk("b_ops",   {op_b_b, op_a_b}, {ONES, {N{1'b0}}});
      chk("b_done_early", done_b, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    chk("b_done",     done_b,      1'b1);
    chk("b_valid_dn", out_valid_b, 1'b0);
    chk("b_pkt_cnt",  pkt_cnt_b,   16'd3);
    @(posedge clk);
    @(negedge clk);
    chk("b_idle_busy", busy_b, 1'b0);
    chk("b_idle_done", done_b, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
